// File: rtl/max7219_display_driver_pkg.sv
// Shared definitions for the MAX7219 display driver: register map, init words,
// FSM state types, digit bundle and word-building helpers.
package max7219_display_driver_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int N_INIT_WORDS  = 5;
  localparam int N_FRAME_WORDS = 6;

  localparam logic [15:0] W_NORMAL_OP  = {REG_SHUTDOWN, 8'h01};
  localparam logic [15:0] W_TEST_OFF   = {REG_TEST,     8'h00};
  localparam logic [15:0] W_DECODE_ALL = {REG_DECODE,   8'hFF};
  localparam logic [15:0] W_SCAN_0_5   = {REG_SCANLIM,  8'h05};

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FRAME} seq_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_TAIL, TX_GAP} tx_state_t;

  // Field order matches the display left to right, so ces_0x sits in the LSBs.
  typedef struct packed {
    logic [2:0] min_x0;
    logic [3:0] min_0x;
    logic [2:0] sec_x0;
    logic [3:0] sec_0x;
    logic [3:0] ces_x0;
    logic [3:0] ces_0x;
  } digits_t;

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    case (idx)
      3'd0:    return W_NORMAL_OP;
      3'd1:    return W_TEST_OFF;
      3'd2:    return W_DECODE_ALL;
      3'd3:    return {REG_INTENSITY, 4'h0, intensity};
      default: return W_SCAN_0_5;
    endcase
  endfunction

  // Digit register N+1 carries digit N; 3-bit tens digits are zero-extended.
  function automatic logic [15:0] digit_word(input logic [2:0] idx, input digits_t d,
                                             input logic [5:0] dp_mask);
    logic [3:0] digit;
    case (idx)
      3'd0:    digit = d.ces_0x;
      3'd1:    digit = d.ces_x0;
      3'd2:    digit = d.sec_0x;
      3'd3:    digit = {1'b0, d.sec_x0};
      3'd4:    digit = d.min_0x;
      default: digit = {1'b0, d.min_x0};
    endcase
    return {REG_DIGIT0 + {5'b0, idx}, dp_mask[idx], 3'b000, digit};
  endfunction

endpackage

// File: rtl/max7219_display_driver_if.sv
// 3-wire SPI link to the MAX7219 (Cs doubles as the LOAD strobe).
interface max7219_display_driver_if;
  logic Mosi;
  logic Cs;
  logic Clk_SPI;

  modport master (output Mosi, Cs, Clk_SPI);
  modport slave  (input  Mosi, Cs, Clk_SPI);
endinterface

// File: rtl/max7219_display_driver_spi_word_tx.sv
// Sends one 16-bit word, SPI mode 0, MSB first: Cs low for 33 half periods,
// then a 2-half-period Cs-high gap. done pulses in the last gap cycle and a
// start in that same cycle chains the next word with no extra idle cycle.
module max7219_display_driver_spi_word_tx
  import max7219_display_driver_pkg::*;
#(
  parameter int SPI_HALF = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        busy,
  max7219_display_driver_if.master spi
);

  localparam int            TW        = $clog2(2 * SPI_HALF);
  localparam logic [TW-1:0] HALF_LAST = TW'(SPI_HALF - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(2 * SPI_HALF - 1);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [3:0]    bit_q;
  logic          hi_q;
  logic [15:0]   shreg_q;
  logic          half_end;
  logic          load;

  assign half_end = (tick_q == HALF_LAST);
  assign done     = (state_q == TX_GAP) && (tick_q == GAP_LAST);
  assign load     = start && ((state_q == TX_IDLE) || done);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  // Next state: shift 16 bits, hold Cs for one tail half period, then the Cs-high gap.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:  if (start) state_d = TX_SHIFT;
      TX_SHIFT: if (half_end && hi_q && (bit_q == 4'd15)) state_d = TX_TAIL;
      TX_TAIL:  if (half_end) state_d = TX_GAP;
      TX_GAP:   if (done) state_d = start ? TX_SHIFT : TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // Datapath: half-period tick counter, clock phase, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (res) begin
      tick_q  <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      shreg_q <= '0;
    end else if (load) begin
      tick_q  <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      shreg_q <= word;
    end else if ((state_q == TX_IDLE) || (state_d != state_q)) begin
      tick_q <= '0;
      hi_q   <= 1'b0;
    end else if ((state_q == TX_SHIFT) && half_end) begin
      tick_q <= '0;
      hi_q   <= ~hi_q;
      // Mosi advances together with the Clk_SPI falling edge.
      if (hi_q) begin
        shreg_q <= {shreg_q[14:0], 1'b0};
        bit_q   <= bit_q + 4'd1;
      end
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // Pin decode: Cs low only while shifting or in the tail, Mosi forced low while Cs is high.
  always_comb begin
    spi.Cs      = 1'b1;
    spi.Clk_SPI = 1'b0;
    spi.Mosi    = 1'b0;
    busy        = (state_q != TX_IDLE);
    if (state_q == TX_SHIFT) begin
      spi.Cs      = 1'b0;
      spi.Clk_SPI = hi_q;
      spi.Mosi    = shreg_q[15];
    end else if (state_q == TX_TAIL) begin
      spi.Cs   = 1'b0;
      spi.Mosi = shreg_q[15];
    end
  end

endmodule

// File: rtl/max7219_display_driver.sv
// Stopwatch display driver: after reset sends the MAX7219 init words, then on
// each (synchronised) rising edge of clk_div with ena high snapshots the six
// digits and sends them as one frame of six register writes.
module max7219_display_driver
  import max7219_display_driver_pkg::*;
#(
  parameter int         SPI_HALF  = 4,
  parameter logic [3:0] INTENSITY = 4'h8,
  parameter logic [5:0] DP_MASK   = 6'b010100
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       clk_div,
  input  logic [3:0] ces_0X,
  input  logic [3:0] ces_X0,
  input  logic [3:0] sec_0X,
  input  logic [2:0] sec_X0,
  input  logic [3:0] min_0X,
  input  logic [2:0] min_X0,
  max7219_display_driver_if.master spi,
  output logic       busy,
  output logic       init_done
);

  seq_state_t  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  sync_q;
  logic        div_prev_q;
  logic        upd;
  logic        pending_q;
  logic        init_done_q;
  logic        frame_start;
  logic        tx_start, tx_done, tx_busy;
  logic [15:0] tx_word;
  digits_t     live, snap_q;

  assign live = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};

  // Two-flop synchroniser for the asynchronous clk_div plus rising-edge detect.
  always_ff @(posedge clk) begin
    if (res) begin
      sync_q     <= '0;
      div_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], clk_div};
      div_prev_q <= sync_q[1];
    end
  end

  assign upd = sync_q[1] & ~div_prev_q;

  // One-deep request flag; an update arriving in the frame-start cycle is kept.
  always_ff @(posedge clk) begin
    if (res)              pending_q <= 1'b0;
    else if (frame_start) pending_q <= upd & ena;
    else if (upd && ena)  pending_q <= 1'b1;
  end

  // Digit snapshot taken in the frame-start cycle.
  // NOTE: snapshot is pure data that is always loaded before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (frame_start) snap_q <= live;
  end

  // Sequencer state register, word index and init-complete flag.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if ((state_q == ST_INIT) && (state_d != ST_INIT)) init_done_q <= 1'b1;
    end
  end

  // Next state: idx counts words already started in the current sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    tx_start    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (!tx_busy || tx_done) begin
          if (idx_q != 3'(N_INIT_WORDS)) begin
            tx_start = 1'b1;
            idx_d    = idx_q + 3'd1;
          end else if (pending_q) begin
            // Chain straight into the first frame so a request made during init is served at once.
            state_d     = ST_FRAME;
            frame_start = 1'b1;
            tx_start    = 1'b1;
            idx_d       = 3'd1;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      ST_IDLE: begin
        if (pending_q && !tx_busy) begin
          state_d     = ST_FRAME;
          frame_start = 1'b1;
          tx_start    = 1'b1;
          idx_d       = 3'd1;
        end
      end
      ST_FRAME: begin
        if (tx_done) begin
          if (idx_q != 3'(N_FRAME_WORDS)) begin
            tx_start = 1'b1;
            idx_d    = idx_q + 3'd1;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs: word to send (live digits feed word 0 in the snapshot cycle) and status.
  always_comb begin
    tx_word   = init_word(idx_q, INTENSITY);
    busy      = tx_busy;
    init_done = init_done_q;
    if (frame_start)               tx_word = digit_word(3'd0, live, DP_MASK);
    else if (state_q == ST_FRAME)  tx_word = digit_word(idx_q, snap_q, DP_MASK);
  end

  max7219_display_driver_spi_word_tx #(
    .SPI_HALF(SPI_HALF)
  ) u_tx (
    .clk  (clk),
    .res  (res),
    .start(tx_start),
    .word (tx_word),
    .done (tx_done),
    .busy (tx_busy),
    .spi  (spi)
  );

endmodule

// File: tb/tb_max7219_display_driver.sv
// Bench for max7219_display_driver: an SPI monitor rebuilds words from the pins
// and expected words come from the display register rules.
module tb_max7219_display_driver;

  localparam int         T         = 4;
  localparam logic [5:0] DP_MASK   = 6'b010100;
  localparam logic [3:0] INTENSITY = 4'h8;

  typedef logic [5:0][3:0]  dig6_t;   // [0]=ces_0X .. [5]=min_X0
  typedef logic [5:0][15:0] frame_t;  // [0]=digit register 1 word
  typedef struct packed { dig6_t d; frame_t exp; } vec_t;
  typedef struct { logic [15:0] w; int bits; int low_len; int gap; int smin; int smax; } rx_t;

  logic clk = 1'b0, res = 1'b1, ena = 1'b0, clk_div = 1'b0;
  logic [3:0] ces_0X = '0, ces_X0 = '0, sec_0X = '0, min_0X = '0;
  logic [2:0] sec_X0 = '0, min_X0 = '0;
  logic busy, init_done;

  max7219_display_driver_if spi_bus ();

  max7219_display_driver #(.SPI_HALF(T), .INTENSITY(INTENSITY), .DP_MASK(DP_MASK)) dut (
    .clk(clk), .res(res), .ena(ena), .clk_div(clk_div),
    .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
    .min_0X(min_0X), .min_X0(min_X0), .spi(spi_bus), .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI monitor, sampled on the falling clk edge.
  rx_t rx_q[$];
  logic cs_prev = 1'b1, sck_prev = 1'b0;
  logic [15:0] sr = '0;
  int nbits = 0, fall_cyc = 0, rise_cyc = -100000, gap_cur = 0;
  int sck_last = -1, smin = 0, smax = 0, cs_falls = 0, mosi_viol = 0;

  always @(negedge clk) begin
    if (spi_bus.Cs && spi_bus.Mosi) mosi_viol++;
    if (cs_prev && !spi_bus.Cs) begin
      fall_cyc = cyc; gap_cur = cyc - rise_cyc; nbits = 0; sr = '0;
      sck_last = -1; smin = 1 << 30; smax = 0; cs_falls++;
    end
    if (!sck_prev && spi_bus.Clk_SPI) begin
      sr = {sr[14:0], spi_bus.Mosi};
      nbits++;
      if (sck_last >= 0) begin
        if (cyc - sck_last < smin) smin = cyc - sck_last;
        if (cyc - sck_last > smax) smax = cyc - sck_last;
      end
      sck_last = cyc;
    end
    if (!cs_prev && spi_bus.Cs) begin
      rx_q.push_back('{w: sr, bits: nbits, low_len: cyc - fall_cyc, gap: gap_cur, smin: smin, smax: smax});
      rise_cyc = cyc;
    end
    cs_prev  = spi_bus.Cs;
    sck_prev = spi_bus.Clk_SPI;
  end

  int n_checks = 0, n_fail = 0, rd = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: digit register n+1 = address, DP bit, three zeros, BCD digit.
  function automatic logic [15:0] model_word(input int n, input int dig);
    int dp = int'((DP_MASK >> n) & 6'd1);
    return 16'((n + 1) * 256 + dp * 128 + dig);
  endfunction

  function automatic frame_t model_frame(input dig6_t d);
    frame_t f;
    for (int n = 0; n < 6; n++) f[n] = model_word(n, int'(d[n]));
    return f;
  endfunction

  task automatic set_digits(input dig6_t d);
    ces_0X = d[0]; ces_X0 = d[1]; sec_0X = d[2];
    sec_X0 = d[3][2:0]; min_0X = d[4]; min_X0 = d[5][2:0];
  endtask

  function automatic dig6_t rand_digits();
    dig6_t d;
    d[0] = 4'($urandom_range(9)); d[1] = 4'($urandom_range(9));
    d[2] = 4'($urandom_range(9)); d[3] = 4'($urandom_range(5));
    d[4] = 4'($urandom_range(9)); d[5] = 4'($urandom_range(5));
    return d;
  endfunction

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() - rd < n && k < budget) begin tick(1); k++; end
    check(name, 32'(rx_q.size() - rd >= n), 32'd1);
  endtask

  task automatic wait_fall(input int f0, input string name);
    int k = 0;
    while (cs_falls == f0 && k < 100) begin tick(1); k++; end
    check(name, 32'(cs_falls != f0), 32'd1);
  endtask

  task automatic pop_word(output rx_t r);
    if (rd < rx_q.size()) r = rx_q[rd];
    else r = '{w: 16'hxxxx, bits: -1, low_len: -1, gap: -1, smin: -1, smax: -1};
    rd++;
  endtask

  task automatic pulse_div();
    int f0 = cs_falls;
    clk_div = 1'b1;
    tick(10);
    clk_div = 1'b0;
    tick(10);
    if (f0 < 0) $display("unreachable");
  endtask

  task automatic expect_frame(input string tag, input frame_t exp, input bit timed, output int gap0);
    rx_t r;
    wait_words(6, 2500, {tag, "_timeout"});
    gap0 = -1;
    for (int i = 0; i < 6; i++) begin
      pop_word(r);
      if (i == 0) gap0 = r.gap;
      check($sformatf("%s_w%0d", tag, i), 32'(r.w), 32'(exp[i]));
      if (timed) begin
        check($sformatf("%s_w%0d_bits", tag, i), 32'(r.bits), 32'd16);
        check($sformatf("%s_w%0d_cs_low", tag, i), 32'(r.low_len), 32'(33 * T));
        check($sformatf("%s_w%0d_sck_min", tag, i), 32'(r.smin), 32'(2 * T));
        check($sformatf("%s_w%0d_sck_max", tag, i), 32'(r.smax), 32'(2 * T));
        if (i > 0) check($sformatf("%s_w%0d_cs_gap", tag, i), 32'(r.gap), 32'(2 * T));
      end
    end
  endtask

  task automatic expect_init(input string tag);
    logic [15:0] init_exp [5];
    rx_t r;
    init_exp = '{16'h0C01, 16'h0F00, 16'h09FF, 16'h0A08, 16'h0B05};
    wait_words(5, 1500, {tag, "_timeout"});
    for (int i = 0; i < 5; i++) begin
      pop_word(r);
      check($sformatf("%s_w%0d", tag, i), 32'(r.w), 32'(init_exp[i]));
    end
  endtask

  initial begin
    vec_t vecs[4];
    dig6_t a, b;
    int k, c0, f0, gap0;

    vecs[0] = '{d: 24'h123456, exp: 96'h0601_0582_0403_0384_0205_0106};
    vecs[1] = '{d: 24'h000000, exp: 96'h0600_0580_0400_0380_0200_0100};
    vecs[2] = '{d: 24'h595999, exp: 96'h0605_0589_0405_0389_0209_0109};
    vecs[3] = '{d: 24'h482037, exp: 96'h0604_0588_0402_0380_0203_0107};

    // Reset state and init sequence.
    res = 1'b1;
    tick(5);
    check("rst_cs", 32'(spi_bus.Cs), 32'd1);
    check("rst_sck", 32'(spi_bus.Clk_SPI), 32'd0);
    check("rst_mosi", 32'(spi_bus.Mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    res = 1'b0;
    c0 = cyc;
    expect_init("init");
    k = 0;
    while (!init_done && k < 100) begin tick(1); k++; end
    check_range("init_done_cycle", cyc - c0, 175 * T - 5, 175 * T + 10);

    // Table-driven frames; the first one also checks SPI timing and busy.
    ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_digits(vecs[i].d);
      f0 = cs_falls;
      clk_div = 1'b1;
      wait_fall(f0, $sformatf("vec%0d_start", i));
      tick(1);
      check($sformatf("vec%0d_busy_hi", i), 32'(busy), 32'd1);
      clk_div = 1'b0;
      expect_frame($sformatf("vec%0d", i), vecs[i].exp, i == 0, gap0);
      tick(2 * T + 2);
      check($sformatf("vec%0d_busy_lo", i), 32'(busy), 32'd0);
    end

    // Randomised frames against the reference model.
    for (int i = 0; i < 4; i++) begin
      a = rand_digits();
      set_digits(a);
      pulse_div();
      expect_frame($sformatf("rand%0d", i), model_frame(a), 1'b0, gap0);
      tick(20);
    end

    // ena low: edges are discarded, then one frame once ena returns.
    ena = 1'b0;
    f0 = cs_falls;
    repeat (3) pulse_div();
    tick(100);
    check("hold_no_cs_fall", 32'(cs_falls - f0), 32'd0);
    check("hold_no_words", 32'(rx_q.size() - rd), 32'd0);
    a = rand_digits();
    set_digits(a);
    ena = 1'b1;
    pulse_div();
    expect_frame("resume", model_frame(a), 1'b0, gap0);
    tick(1000);
    check("resume_single_frame", 32'(rx_q.size() - rd), 32'd0);

    // Second edge and digit change mid-frame: old digits now, new digits once.
    a = rand_digits();
    b = rand_digits();
    b[0] = (a[0] == 4'd9) ? 4'd0 : a[0] + 4'd1;
    set_digits(a);
    f0 = cs_falls;
    clk_div = 1'b1;
    wait_fall(f0, "mid_start");
    set_digits(b);
    tick(10);
    clk_div = 1'b0;
    tick(10);
    clk_div = 1'b1;
    tick(10);
    clk_div = 1'b0;
    expect_frame("mid_old", model_frame(a), 1'b0, gap0);
    expect_frame("mid_new", model_frame(b), 1'b0, gap0);
    tick(1500);
    check("mid_then_idle", 32'(rx_q.size() - rd), 32'd0);

    // Reset during bit 7 of a frame word aborts at once; init resent after release.
    f0 = cs_falls;
    clk_div = 1'b1;
    wait_fall(f0, "abort_start");
    k = 0;
    while (nbits < 7 && k < 200) begin tick(1); k++; end
    check("abort_reach_bit7", 32'(nbits), 32'd7);
    res = 1'b1;
    clk_div = 1'b0;
    tick(1);
    check("abort_cs", 32'(spi_bus.Cs), 32'd1);
    check("abort_sck", 32'(spi_bus.Clk_SPI), 32'd0);
    check("abort_mosi", 32'(spi_bus.Mosi), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    tick(3);
    rd = rx_q.size();
    res = 1'b0;

    // clk_div edge during init: frame follows the last init word after the Cs gap.
    a = rand_digits();
    set_digits(a);
    tick(20);
    pulse_div();
    expect_init("reinit");
    expect_frame("post_init", model_frame(a), 1'b0, gap0);
    check_range("post_init_gap", gap0, 2 * T, 2 * T + 1);

    check("mosi_low_when_cs_high", 32'(mosi_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
